// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle load/store responder backed by an internal word array.
// One request in flight at a time; pause holds the pipeline until the response cycle.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        pause,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  logic [31:0] mem [DEPTH];

  logic                  a_we;
  logic [ADDR_WIDTH+1:0] a_addr;
  logic [31:0]           a_wdata;
  logic [3:0]            a_be;
  logic [ADDR_WIDTH-1:0] a_idx;
  logic                  a_aligned;
  logic [31:0]           a_word;
  logic [31:0]           a_merged;
  logic                  accept;
  logic                  do_access;
  logic                  mem_we;
  logic                  unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];
  assign accept      = req_valid && (state_q != WAIT);
  assign pause       = rst && (req_valid || (state_q == WAIT));

  // Outside WAIT an access only happens for LATENCY=1, which uses the live request.
  always_comb begin
    if (state_q == WAIT) begin
      a_we    = we_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
      a_be    = be_q;
    end else begin
      a_we    = req_we;
      a_addr  = req_addr[ADDR_WIDTH+1:0];
      a_wdata = req_wdata;
      a_be    = req_be;
    end
    a_idx     = a_addr[ADDR_WIDTH+1:2];
    a_aligned = (a_addr[1:0] == 2'b00);
    a_word    = mem[a_idx];
    a_merged  = a_word;
    for (int i = 0; i < 4; i++) begin
      if (a_be[i]) a_merged[8*i +: 8] = a_wdata[8*i +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    do_access    = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;

    case (state_q)
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd2) begin
          do_access = 1'b1;
          state_d   = RESP;
        end
      end
      default: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr[ADDR_WIDTH+1:0];
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = 4'(LATENCY);
          if (LATENCY == 1) begin
            do_access = 1'b1;
            state_d   = RESP;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    endcase

    if (do_access) begin
      resp_valid_d = 1'b1;
      resp_err_d   = !a_aligned;
      resp_rdata_d = (a_aligned && !a_we) ? a_word : 32'h0;
    end
  end

  assign mem_we = rst && do_access && a_we && a_aligned;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // The array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[a_idx] <= a_merged;
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 3, 4, 1) driven with directed and
// random requests, compared against a word-array model updated per transaction.
module tb_dmem_responder;

  localparam int AW    = 10;
  localparam int NI    = 3;
  localparam int WORDS = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]       rst_n;
  logic [NI-1:0]       req_valid;
  logic [NI-1:0]       req_we;
  logic [NI-1:0][31:0] req_addr;
  logic [NI-1:0][31:0] req_wdata;
  logic [NI-1:0][3:0]  req_be;
  logic [NI-1:0]       pause;
  logic [NI-1:0]       resp_valid;
  logic [NI-1:0][31:0] resp_rdata;
  logic [NI-1:0]       resp_err;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_responder #(
      .ADDR_WIDTH(AW),
      .LATENCY   ((g == 0) ? 3 : ((g == 1) ? 4 : 1))
    ) u_dut (
      .clk       (clk),
      .rst       (rst_n[g]),
      .req_valid (req_valid[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_be    (req_be[g]),
      .pause     (pause[g]),
      .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  logic [31:0] mdl [NI][WORDS];
  int n_vec = 0;
  int n_err = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 3 : ((k == 1) ? 4 : 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: one word array per instance; index is the byte address divided by 4, modulo depth.
  task automatic model(input int k, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output logic [31:0] e_rd, output logic e_err);
    int unsigned w;
    w = int'((addr / 4) % WORDS);
    if (addr % 4 != 0) begin
      e_err = 1'b1;
      e_rd  = 32'h0;
    end else if (we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mdl[k][w][8*i +: 8] = wdata[8*i +: 8];
      e_err = 1'b0;
      e_rd  = 32'h0;
    end else begin
      e_err = 1'b0;
      e_rd  = mdl[k][w];
    end
  endtask

  task automatic scramble(input int k);
    req_we[k]    = 1'($urandom);
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;
    req_be[k]    = 4'($urandom);
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid[k] = 1'b0;
      scramble(k);
      #1;
      chk("idle_outs", {resp_rdata[k], resp_err[k], resp_valid[k], pause[k]}, 64'h0);
    end
  endtask

  // Presents a request in the current cycle and follows it to its response cycle.
  // Returns at the response cycle with req_valid low, so a following call is back-to-back.
  task automatic xact(input int k, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      output logic [31:0] got_rd);
    logic [31:0] e_rd;
    logic        e_err;
    model(k, we, addr, wdata, be, e_rd, e_err);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_be[k]    = be;
    #1;
    chk("pause_accept", pause[k], 1);
    for (int i = 1; i < lat_of(k); i++) begin
      @(negedge clk);
      req_valid[k] = 1'($urandom);
      scramble(k);
      #1;
      chk("wait_outs", {resp_rdata[k], resp_err[k], resp_valid[k], pause[k]}, 64'h1);
    end
    @(negedge clk);
    req_valid[k] = 1'b0;
    scramble(k);
    #1;
    chk("resp_valid", resp_valid[k], 1);
    chk("resp_err", resp_err[k], e_err);
    chk("resp_rdata", resp_rdata[k], e_rd);
    chk("pause_resp", pause[k], 0);
    got_rd = resp_rdata[k];
  endtask

  initial begin
    logic [31:0] rd;
    logic        we;
    logic [31:0] addr;
    int          w, mis, up, gap;

    for (int k = 0; k < NI; k++) begin
      rst_n[k]     = 1'b0;
      req_valid[k] = 1'b1;
      scramble(k);
    end
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < NI; k++)
      chk("reset_outs", {resp_rdata[k], resp_err[k], resp_valid[k], pause[k]}, 64'h0);
    for (int k = 0; k < NI; k++) begin
      rst_n[k]     = 1'b1;
      req_valid[k] = 1'b0;
    end
    @(negedge clk);

    // LATENCY=3: store/load, byte merge, back-to-back, misaligned.
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
    idle(0, 1);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, rd);
    chk("load_deadbeef", rd, 32'hDEADBEEF);
    idle(0, 1);
    xact(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd);
    idle(0, 1);
    xact(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd);
    idle(0, 1);
    xact(0, 1'b0, 32'h20, 32'h0, 4'h0, rd);
    chk("byte_merge", rd, 32'h11BB33DD);
    idle(0, 2);
    xact(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, rd);
    xact(0, 1'b0, 32'h30, 32'h0, 4'h0, rd);
    chk("b2b_load", rd, 32'hCAFEF00D);
    idle(0, 1);
    xact(0, 1'b1, 32'h40, 32'h55AA55AA, 4'hF, rd);
    idle(0, 1);
    xact(0, 1'b0, 32'h41, 32'h0, 4'h0, rd);
    xact(0, 1'b1, 32'h42, 32'hFFFFFFFF, 4'hF, rd);
    xact(0, 1'b1, 32'h40, 32'h0, 4'h0, rd);
    idle(0, 1);
    xact(0, 1'b0, 32'h40, 32'h0, 4'h0, rd);
    chk("misaligned_kept", rd, 32'h55AA55AA);
    idle(0, 1);

    // LATENCY=4: reset two cycles after acceptance aborts the store.
    xact(1, 1'b1, 32'h50, 32'h0, 4'hF, rd);
    idle(1, 1);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_addr[1]  = 32'h50;
    req_wdata[1] = 32'h12345678;
    req_be[1]    = 4'hF;
    #1;
    chk("rst_pause_t0", pause[1], 1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    #1;
    chk("rst_pause_t1", pause[1], 1);
    @(negedge clk);
    rst_n[1]     = 1'b0;
    req_valid[1] = 1'b1;
    req_wdata[1] = 32'hFFFFFFFF;
    #1;
    chk("rst_pause_t2", pause[1], 0);
    chk("rst_vld_t2", resp_valid[1], 0);
    @(negedge clk);
    rst_n[1]     = 1'b1;
    req_valid[1] = 1'b0;
    #1;
    chk("rst_outs_t3", {resp_rdata[1], resp_err[1], resp_valid[1], pause[1]}, 64'h0);
    idle(1, 5);
    xact(1, 1'b0, 32'h50, 32'h0, 4'h0, rd);
    chk("rst_no_store", rd, 32'h0);
    idle(1, 1);

    // LATENCY=1: alternating stores and loads every cycle, plus aliasing.
    for (int i = 0; i < 8; i++) begin
      xact(2, 1'b1, 32'(i * 4), $urandom, 4'($urandom), rd);
      xact(2, 1'b0, 32'(i * 4), 32'h0, 4'h0, rd);
    end
    xact(2, 1'b1, 32'h50 + (32'h1 << (AW + 2)), 32'hA5A5_0F0F, 4'hF, rd);
    xact(2, 1'b0, 32'h50, 32'h0, 4'h0, rd);
    chk("alias_load", rd, 32'hA5A5_0F0F);
    idle(2, 1);

    // Random traffic on a preinitialised 64-word region, with aliasing and misalignment.
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 64; i++)
        xact(k, 1'b1, 32'(i * 4), $urandom, 4'hF, rd);
      idle(k, 1);
      for (int n = 0; n < 60; n++) begin
        we   = 1'($urandom_range(0, 1));
        w    = $urandom_range(0, 63);
        mis  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        up   = $urandom_range(0, 15);
        addr = (32'(up) << (AW + 2)) | (32'(w) << 2) | 32'(mis);
        xact(k, we, addr, $urandom, 4'($urandom), rd);
        gap = $urandom_range(0, 2);
        if (gap > 0) idle(k, gap);
      end
      idle(k, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
